// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: runtime CPOL/CPHA, burst mode that keeps SS low between words.
// Latency: ss_n low 1 cycle after start, done at 1+(2*DATA_BITS+1)*CLK_DIV, busy low CLK_DIV later.
// Backpressure: start is honoured only in IDLE or BURST; elsewhere it is dropped, never queued.
module spi_master_multi #(
  parameter int DATA_BITS = 8,
  parameter int SEL_BITS  = 2,
  parameter int CLK_DIV   = 25
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic [SEL_BITS-1:0]      slave_sel,
  input  logic                     hold_ss,
  input  logic [DATA_BITS-1:0]     data_in,
  input  logic                     miso,
  output logic                     mosi,
  output logic                     sclk,
  output logic [2**SEL_BITS-1:0]   ss_n,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_BITS-1:0]     data_out
);

  localparam int NUM_SLAVES = 2**SEL_BITS;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int EDGES      = 2*DATA_BITS;
  localparam int EDGE_W     = $clog2(EDGES+1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, BURST, GAP} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_BITS-1:0]  tx_sr;
  logic [DATA_BITS-1:0]  rx_sr;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  hold_q;
  logic [SEL_BITS-1:0]   sel_q;

  logic div_end;
  logic load;
  logic edge_now;
  logic sample_now;
  logic last_edge;

  always_comb begin
    div_end    = (div_cnt == DIV_W'(CLK_DIV-1));
    load       = start && (state == IDLE || state == BURST);
    edge_now   = div_end && (state == LEAD || state == SHIFT);
    // Odd-numbered edges (edge_cnt even) are leading; cpha picks which kind samples.
    sample_now = (~edge_cnt[0]) ^ cpha_q;
    last_edge  = (edge_cnt == EDGE_W'(EDGES-1));
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      hold_q   <= 1'b0;
      sel_q    <= '0;
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      ss_n     <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done    <= 1'b0;
      // Waiting states hold the divider at zero so every timed state starts a fresh period.
      div_cnt <= (state == IDLE || state == BURST || div_end) ? '0 : div_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state <= LEAD;
            busy  <= 1'b1;
            sel_q <= slave_sel;
            ss_n  <= ~(NUM_SLAVES'(1) << slave_sel);
          end
        end
        LEAD: begin
          if (div_end) state <= SHIFT;
        end
        SHIFT: begin
          if (div_end && last_edge) state <= TRAIL;
        end
        TRAIL: begin
          if (div_end) begin
            data_out <= rx_sr;
            done     <= 1'b1;
            if (hold_q) begin
              state <= BURST;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
              ss_n  <= '1;
            end
          end
        end
        BURST: begin
          if (start) begin
            state <= LEAD;
            busy  <= 1'b1;
            ss_n  <= ~(NUM_SLAVES'(1) << sel_q);
          end else if (!hold_ss) begin
            state <= GAP;
            busy  <= 1'b1;
            ss_n  <= '1;
          end
        end
        GAP: begin
          if (div_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        hold_q   <= hold_ss;
        sclk     <= cpol;
        edge_cnt <= '0;
        // cpha=0 presents the MSB before the first edge; cpha=1 drives it on the leading edge.
        if (cpha) begin
          tx_sr <= data_in;
          mosi  <= 1'b0;
        end else begin
          tx_sr <= data_in << 1;
          mosi  <= data_in[DATA_BITS-1];
        end
      end

      if (edge_now) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (sample_now) begin
          rx_sr <= {rx_sr[DATA_BITS-2:0], miso};
        end else if (!last_edge) begin
          mosi  <= tx_sr[DATA_BITS-1];
          tx_sr <= {tx_sr[DATA_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: mode table, burst, ignored start, mid-word reset, 16-bit instance.
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset_n;

  logic       start1, cpol1, cpha1, hold1, miso1, mosi1, sclk1, busy1, done1;
  logic [1:0] sel1;
  logic [7:0] din1, dout1;
  logic [3:0] ss1;

  logic        start2, cpol2, cpha2, hold2, miso2, mosi2, sclk2, busy2, done2;
  logic [1:0]  sel2;
  logic [15:0] din2, dout2;
  logic [3:0]  ss2;

  logic use_loop;
  logic s_miso;
  assign miso1 = use_loop ? mosi1 : s_miso;
  assign miso2 = mosi2;

  spi_master_multi dut1 (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start1), .cpol(cpol1), .cpha(cpha1),
    .slave_sel(sel1), .hold_ss(hold1), .data_in(din1), .miso(miso1), .mosi(mosi1),
    .sclk(sclk1), .ss_n(ss1), .busy(busy1), .done(done1), .data_out(dout1)
  );

  spi_master_multi #(.DATA_BITS(16), .SEL_BITS(2), .CLK_DIV(2)) dut2 (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start2), .cpol(cpol2), .cpha(cpha2),
    .slave_sel(sel2), .hold_ss(hold2), .data_in(din2), .miso(miso2), .mosi(mosi2),
    .sclk(sclk2), .ss_n(ss2), .busy(busy2), .done(done2), .data_out(dout2)
  );

  // Behavioural SPI slave on dut1, sampled once per system clock.
  logic       t_cpol = 1'b0, t_cpha = 1'b0;
  logic [7:0] slave_word = 8'h00, s_sr = 8'h00, s_cap = 8'h00;
  logic       s_act_prev = 1'b0, s_sclk_prev = 1'b0;
  initial s_miso = 1'b0;

  always @(negedge clk) begin
    logic act;
    act = (ss1 !== 4'hF);
    if (act && !s_act_prev) begin
      s_sr  = slave_word;
      s_cap = 8'h00;
      if (!t_cpha) begin
        s_miso = s_sr[7];
        s_sr   = s_sr << 1;
      end
    end else if (act && s_act_prev && sclk1 !== s_sclk_prev) begin
      if ((sclk1 != t_cpol) ^ t_cpha) begin
        s_cap = {s_cap[6:0], mosi1};
      end else begin
        s_miso = s_sr[7];
        s_sr   = s_sr << 1;
      end
    end
    s_act_prev  = act;
    s_sclk_prev = sclk1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_word(input logic c_pol, input logic c_pha, input logic [1:0] s,
                          input logic [7:0] d, input logic h,
                          output int first_edge, output int n_edges, output int done_cyc,
                          output int busy_low, output logic [3:0] ss_at1, output logic sclk_at1);
    logic prev;
    first_edge = -1; n_edges = 0; done_cyc = -1; busy_low = -1;
    @(negedge clk);
    t_cpol = c_pol; t_cpha = c_pha;
    cpol1 = c_pol; cpha1 = c_pha; sel1 = s; din1 = d; hold1 = h; start1 = 1'b1;
    @(negedge clk);
    start1   = 1'b0;
    ss_at1   = ss1;
    sclk_at1 = sclk1;
    prev     = sclk1;
    for (int c = 1; c <= 600; c++) begin
      if (sclk1 !== prev) begin
        n_edges++;
        if (first_edge < 0) first_edge = c;
      end
      prev = sclk1;
      if (done1 === 1'b1 && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && busy1 === 1'b0) begin
        busy_low = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [1:0] sel;
    logic [7:0] din;
    logic       loopback;
    logic [7:0] slave_word;
    logic [7:0] exp_dout;
    logic [3:0] exp_ss;
    int         exp_first;
    int         exp_edges;
    int         exp_done;
    int         exp_busy_low;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int fe, ne, dc, bl, dn, d1, d2, ss_bad;
    logic [3:0] s_at1, ss_end;
    logic       k_at1, busy_burst;
    logic [7:0] dout_a;
    logic       prev2;

    vecs[0] = '{1'b0, 1'b0, 2'd1, 8'hA5, 1'b1, 8'h00, 8'hA5, 4'b1101, 26, 16, 426, 451};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 8'hC3, 1'b0, 8'h3C, 8'h3C, 4'b1110, 26, 16, 426, 451};
    vecs[2] = '{1'b0, 1'b1, 2'd3, 8'h5A, 1'b0, 8'h96, 8'h96, 4'b0111, 26, 16, 426, 451};
    vecs[3] = '{1'b1, 1'b0, 2'd2, 8'h0F, 1'b1, 8'h00, 8'h0F, 4'b1011, 26, 16, 426, 451};

    reset_n = 1'b0; use_loop = 1'b1;
    start1 = 0; cpol1 = 0; cpha1 = 0; hold1 = 0; sel1 = 0; din1 = 0;
    start2 = 0; cpol2 = 0; cpha2 = 0; hold2 = 0; sel2 = 0; din2 = 0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk1, 0);
    check("rst_mosi", mosi1, 0);
    check("rst_ss_n", ss1, 4'hF);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_data_out", dout1, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      use_loop   = vecs[i].loopback;
      slave_word = vecs[i].slave_word;
      run_word(vecs[i].cpol, vecs[i].cpha, vecs[i].sel, vecs[i].din, 1'b0,
               fe, ne, dc, bl, s_at1, k_at1);
      check($sformatf("v%0d_ss_n", i), s_at1, vecs[i].exp_ss);
      check($sformatf("v%0d_sclk_idle", i), k_at1, vecs[i].cpol);
      check($sformatf("v%0d_first_edge", i), fe, vecs[i].exp_first);
      check($sformatf("v%0d_edges", i), ne, vecs[i].exp_edges);
      check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
      check($sformatf("v%0d_data_out", i), dout1, vecs[i].exp_dout);
      check($sformatf("v%0d_busy_low", i), bl, vecs[i].exp_busy_low);
      check($sformatf("v%0d_slave_capture", i), s_cap, vecs[i].din);
    end

    // Two-word burst on slave 2; second start also tries slave 0, which must be ignored.
    use_loop = 1'b1;
    dn = 0; d1 = -1; d2 = -1; ss_bad = 0; ss_end = 4'h0; busy_burst = 1'bx; dout_a = 8'h00;
    @(negedge clk);
    t_cpol = 0; t_cpha = 0;
    cpol1 = 0; cpha1 = 0; sel1 = 2'd2; din1 = 8'h11; hold1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 900; c++) begin
      if (done1 === 1'b1) begin
        dn++;
        if (d1 < 0) begin d1 = c; dout_a = dout1; end
        else d2 = c;
      end
      if (dn < 2 && ss1 !== 4'b1011) ss_bad++;
      if (c == 866) ss_end = ss1;
      if (c == 430) busy_burst = busy1;
      if (c == 440) begin start1 = 1'b1; din1 = 8'h22; hold1 = 1'b0; sel1 = 2'd0; end
      if (c == 441) start1 = 1'b0;
      @(negedge clk);
    end
    check("burst_done_count", dn, 2);
    check("burst_done1_cycle", d1, 426);
    check("burst_done2_cycle", d2, 866);
    check("burst_word1", dout_a, 8'h11);
    check("burst_word2", dout1, 8'h22);
    check("burst_ss_held", ss_bad, 0);
    check("burst_ss_release", ss_end, 4'hF);
    check("burst_busy_idle", busy_burst, 0);

    // start during an active word is dropped.
    dn = 0; d1 = -1;
    @(negedge clk);
    cpol1 = 0; cpha1 = 0; sel1 = 2'd0; din1 = 8'h5A; hold1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 500; c++) begin
      if (done1 === 1'b1) begin dn++; if (d1 < 0) d1 = c; end
      if (c == 100) begin start1 = 1'b1; din1 = 8'hFF; end
      if (c == 101) start1 = 1'b0;
      @(negedge clk);
    end
    check("ignore_done_count", dn, 1);
    check("ignore_done_cycle", d1, 426);
    check("ignore_data_out", dout1, 8'h5A);

    // Reset in the middle of SHIFT (sclk high after 7 edges in mode 0).
    dn = 0;
    @(negedge clk);
    cpol1 = 0; cpha1 = 0; sel1 = 2'd3; din1 = 8'h3C; hold1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (done1 === 1'b1) dn++;
      @(negedge clk);
    end
    check("pre_reset_sclk", sclk1, 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_ss_n", ss1, 4'hF);
    check("mid_reset_sclk", sclk1, 0);
    check("mid_reset_busy", busy1, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (done1 === 1'b1) dn++;
      @(negedge clk);
    end
    check("mid_reset_no_done", dn, 0);
    check("mid_reset_state_idle", busy1, 0);
    run_word(1'b0, 1'b0, 2'd1, 8'h96, 1'b0, fe, ne, dc, bl, s_at1, k_at1);
    check("post_reset_done_cycle", dc, 426);
    check("post_reset_data_out", dout1, 8'h96);
    check("post_reset_ss_n", s_at1, 4'b1101);

    // 16-bit, CLK_DIV=2 instance in mode 1 with loopback.
    fe = -1; ne = 0; dc = -1; bl = -1;
    @(negedge clk);
    cpol2 = 0; cpha2 = 1; sel2 = 2'd0; din2 = 16'hBEEF; hold2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    s_at1 = ss2;
    prev2 = sclk2;
    for (int c = 1; c <= 120; c++) begin
      if (sclk2 !== prev2) begin ne++; if (fe < 0) fe = c; end
      prev2 = sclk2;
      if (done2 === 1'b1 && dc < 0) dc = c;
      if (dc >= 0 && busy2 === 1'b0 && bl < 0) bl = c;
      @(negedge clk);
    end
    check("w16_ss_n", s_at1, 4'b1110);
    check("w16_first_edge", fe, 3);
    check("w16_edges", ne, 32);
    check("w16_done_cycle", dc, 67);
    check("w16_data_out", dout2, 16'hBEEF);
    check("w16_busy_low", bl, 69);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
